data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Data-memory responder that services the CPU's load/store port (memread/memwrite, mem_length, mem_signed) through a valid/ready request and response handshake. It is the far end of that memory interface. It holds a word-organised RAM and applies byte-lane write masking on stores. Loads are returned sign- or zero-extended according to the request. A configurable wait-state count lets the core be exercised against non-ideal memory timing.

Parameters:
DEPTH, 256, number of 32-bit words; the word index is req_addr[31:2] and must be < DEPTH.
LATENCY, 1, wait-state cycles between request acceptance and response (0..15).

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_length  input  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  input  1  load extension: 1 = sign, 0 = zero
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts response
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_error  output  1  misaligned, out of range, or illegal length

Behaviour:
- Reset (reset == 0 at a clock edge): state IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, wait counter = 0.
- Reset mid-transaction drops the transaction. A store already committed to RAM stays committed. RAM contents are never cleared by reset.
- States and transitions:
  - IDLE, req_ready = 1. Handshake is req_valid & req_ready; on handshake, capture write, addr, wdata, length and signed.
    - LATENCY == 0: go to RESP.
    - Otherwise: load the counter with LATENCY-1 and go to WAIT.
  - WAIT, req_ready = 0. Decrement the counter each cycle. When the counter reaches 0, go to RESP.
  - Entering RESP:
    - Perform the access and register rsp_rdata and rsp_error.
    - rsp_valid = 1 and is held until rsp_valid & rsp_ready.
    - On that handshake, go to IDLE with rsp_valid = 0.
- Request-to-response latency:
  - rsp_valid rises LATENCY+1 cycles after the accepting edge.
  - Back-to-back requests: a new request is accepted no earlier than the cycle after the response handshake.
  - req_ready is 0 in WAIT and RESP. No pipelining; one outstanding transaction.
- Error checks, evaluated on the captured request:
  - length 11 is an error.
  - half with addr[0] = 1 is an error.
  - word with addr[1:0] != 0 is an error.
  - addr[31:2] >= DEPTH is an error.
  - On error: rsp_error = 1, rsp_rdata = 0, no RAM write.
- Store (no error): write into word addr[31:2].
  - byte: lane addr[1:0] receives wdata[7:0].
  - half: lanes {addr[1],0} and {addr[1],1} receive wdata[15:0].
  - word: all four lanes receive wdata.
  - Other lanes are unchanged. rsp_rdata = 0.
- Load (no error): select the lane(s) by address. Byte order is little-endian: lane 0 = bits [7:0].
  - byte: extend from bit 7.
  - half: extend from bit 15.
  - word: returned unchanged.
  - Sign extension when req_signed = 1, zero extension otherwise.
- Request inputs are ignored outside IDLE. A held req_valid is not accepted twice.

Decomposition:
- Shared package data_mem_pkg:
  - length encodings LEN_BYTE = 2'b00, LEN_HALF = 2'b01, LEN_WORD = 2'b10.
  - state enum IDLE / WAIT / RESP.
  - error-check helper function.
- One sub-module, data_mem_lane: combinational byte-enable generation and load lane select/extend.
- The RAM array, FSM and counter stay in the top.

Test Plan:
1. LATENCY = 1. Store word 0x8765_4321 at 0x10, then byte-signed load at 0x13 → rsp_rdata = 0xFFFF_FF87, rsp_error = 0. rsp_valid rises 2 cycles after each accept.
2. Byte store 0xAB at 0x11 over word 0x8765_4321 → word-load 0x10 returns 0x8765_AB21. Half-unsigned load at 0x12 returns 0x0000_8765.
3. Word load at 0x06, half load at 0x05, length 11 at 0x00, and word store at DEPTH*4 → each gives rsp_error = 1, rsp_rdata = 0. The contents at 0x04 are unchanged.
4. rsp_ready held 0 for 5 cycles → rsp_valid and rsp_rdata stay stable and req_ready stays 0. Acceptance resumes the cycle after the handshake.
5. LATENCY = 0 with back-to-back requests and rsp_ready = 1 → a response every 2 cycles, in order, with correct data.
6. Reset asserted in WAIT of a load → the next cycle shows IDLE, req_ready = 1, rsp_valid = 0, and no response is ever issued. A prior store remains readable.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory responder: length codes, FSM states
// and the access legality check used on the captured request.
package data_mem_pkg;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic access_error(input logic [31:0] addr,
                                        input logic [1:0]  length,
                                        input int unsigned depth);
    logic err;
    err = 1'b0;
    case (length)
      LEN_BYTE: err = 1'b0;
      LEN_HALF: err = addr[0];
      LEN_WORD: err = |addr[1:0];
      default:  err = 1'b1;
    endcase
    if ({2'b00, addr[31:2]} >= 32'(depth)) err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/data_mem_lane.sv
// Byte-lane steering: store byte enables / replicated write data, and load
// lane select with sign or zero extension. Purely combinational.
module data_mem_lane
  import data_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  length,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  assign shifted = rword >> {addr_lo, 3'b000};

  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = wdata;
    load_data   = rword;
    case (length)
      LEN_BYTE: begin
        byte_en     = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        load_data   = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      end
      LEN_HALF: begin
        byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        load_data   = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      end
      LEN_WORD: byte_en = 4'b1111;
      default:  byte_en = 4'b0000;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data RAM behind a valid/ready load/store port; response LATENCY+1
// cycles after acceptance, one transaction outstanding, response held until rsp_ready.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_length,
  input  logic        req_signed,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_write, cap_signed;
  logic [31:0] cap_addr, cap_wdata;
  logic [1:0]  cap_length;

  logic        acc_write, acc_signed, acc_err, do_access;
  logic [31:0] acc_addr, acc_wdata;
  logic [1:0]  acc_length;
  logic [AW-1:0] widx;
  logic [31:0] rword, load_data, wdata_lanes;
  logic [3:0]  byte_en;

  logic [31:0] mem [DEPTH];

  // With zero wait states the access happens on the accepting edge, so the
  // live request is used instead of the not-yet-captured copy.
  assign acc_write  = (state == IDLE) ? req_write  : cap_write;
  assign acc_signed = (state == IDLE) ? req_signed : cap_signed;
  assign acc_addr   = (state == IDLE) ? req_addr   : cap_addr;
  assign acc_wdata  = (state == IDLE) ? req_wdata  : cap_wdata;
  assign acc_length = (state == IDLE) ? req_length : cap_length;

  assign do_access = ((state == IDLE) && req_valid && (LATENCY == 0)) ||
                     ((state == WAIT) && (cnt == 4'd0));
  assign acc_err   = access_error(acc_addr, acc_length, DEPTH);
  assign widx      = acc_addr[AW+1:2];
  assign rword     = mem[widx];

  data_mem_lane u_lane (
    .addr_lo     (acc_addr[1:0]),
    .length      (acc_length),
    .is_signed   (acc_signed),
    .wdata       (acc_wdata),
    .rword       (rword),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .load_data   (load_data)
  );

  // RAM has no reset; a reset on the access edge suppresses the write.
  always_ff @(posedge clock) begin
    if (reset && do_access && acc_write && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[widx][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      cnt       <= '0;
    end else begin
      if (do_access) begin
        state     <= RESP;
        req_ready <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_error <= acc_err;
        rsp_rdata <= (acc_write || acc_err) ? 32'd0 : load_data;
      end
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_write  <= req_write;
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
            cap_length <= req_length;
            cap_signed <= req_signed;
            if (LATENCY != 0) begin
              cnt       <= CNT_INIT;
              state     <= WAIT;
              req_ready <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: instance 0 has LATENCY=1, instance 1 has LATENCY=0.
// Directed table, hand sequences and random traffic against a byte-array model.
module tb_data_mem_responder;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  rv, rr;
  logic        wr, sg;
  logic [31:0] addr, wd;
  logic [1:0]  len;
  logic        rdy0, rdy1, vld0, vld1, err0, err1;
  logic [31:0] rdat0, rdat1;
  logic [1:0]  rdy, vld, errv;

  assign rdy  = {rdy1, rdy0};
  assign vld  = {vld1, vld0};
  assign errv = {err1, err0};

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
    .clock(clk), .reset(rst_n), .req_valid(rv[0]), .req_ready(rdy0),
    .req_write(wr), .req_addr(addr), .req_wdata(wd), .req_length(len),
    .req_signed(sg), .rsp_valid(vld0), .rsp_ready(rr[0]),
    .rsp_rdata(rdat0), .rsp_error(err0));

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut_l0 (
    .clock(clk), .reset(rst_n), .req_valid(rv[1]), .req_ready(rdy1),
    .req_write(wr), .req_addr(addr), .req_wdata(wd), .req_length(len),
    .req_signed(sg), .rsp_valid(vld1), .rsp_ready(rr[1]),
    .rsp_rdata(rdat1), .rsp_error(err1));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] rdv(input int d);
    return (d == 0) ? rdat0 : rdat1;
  endfunction

  // Reference memory: one flat byte array per instance, little-endian.
  logic [7:0] rm [2][DEPTH*4];

  task automatic model(input int d, input logic w, input logic [31:0] a,
                       input logic [31:0] dat, input logic [1:0] l, input logic s,
                       output logic [31:0] rd, output logic e);
    int nb;
    longint v;
    nb = (l == 2'd3) ? 0 : (1 << l);
    e  = (l == 2'd3) || (l == 2'd1 && a % 2 != 0) || (l == 2'd2 && a % 4 != 0) ||
         (a / 4 >= DEPTH);
    rd = 32'd0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < nb; i++) rm[d][a+i] = 8'((dat >> (8*i)) & 32'hFF);
      end else begin
        v = 0;
        for (int i = 0; i < nb; i++) v += longint'(rm[d][a+i]) << (8*i);
        if (s && nb < 4 && ((v >> (8*nb - 1)) & 1) == 1) v -= (longint'(1) << (8*nb));
        rd = v[31:0];
      end
    end
  endtask

  task automatic txn(input int d, input logic w, input logic [31:0] a,
                     input logic [31:0] dat, input logic [1:0] l, input logic s,
                     input int hold, input logic [31:0] exp_rd, input logic exp_e);
    int n;
    int lat;
    @(negedge clk);
    wr = w; addr = a; wd = dat; len = l; sg = s; rv[d] = 1'b1;
    n = 0;
    while (!rdy[d] && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_idle", 32'(rdy[d]), 32'd1);
    @(posedge clk); #1;
    rv[d] = 1'b0;
    lat = 1;
    while (!vld[d] && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, (d == 0) ? 32'd2 : 32'd1);
    chk("rsp_rdata", rdv(d), exp_rd);
    chk("rsp_error", 32'(errv[d]), 32'(exp_e));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(vld[d]), 32'd1);
      chk("hold_rdata", rdv(d), exp_rd);
      chk("hold_req_ready", 32'(rdy[d]), 32'd0);
    end
    rr[d] = 1'b1;
    @(posedge clk); #1;
    rr[d] = 1'b0;
    chk("post_hs_valid", 32'(vld[d]), 32'd0);
    chk("post_hs_ready", 32'(rdy[d]), 32'd1);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] dat;
    logic [1:0]  l;
    logic        s;
    int          hold;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  initial begin
    vec_t        tbl[$];
    logic [31:0] mrd;
    logic        me;
    logic        w, s;
    logic [31:0] a, dat;
    logic [1:0]  l;

    rst_n = 1'b0; rv = '0; rr = '0;
    wr = 1'b0; sg = 1'b0; addr = '0; wd = '0; len = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", 32'(rdy[d]), 32'd1);
      chk("rst_rsp_valid", 32'(vld[d]), 32'd0);
      chk("rst_rsp_rdata", rdv(d), 32'd0);
      chk("rst_rsp_error", 32'(errv[d]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors on the LATENCY=1 instance.
    tbl.push_back('{1'b1, 32'h10,  32'h8765_4321, 2'd2, 1'b0, 0, 32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h13,  32'h0,         2'd0, 1'b1, 5, 32'hFFFF_FF87, 1'b0});
    tbl.push_back('{1'b1, 32'h11,  32'h0000_00AB, 2'd0, 1'b0, 0, 32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h10,  32'h0,         2'd2, 1'b0, 0, 32'h8765_AB21, 1'b0});
    tbl.push_back('{1'b0, 32'h12,  32'h0,         2'd1, 1'b0, 0, 32'h0000_8765, 1'b0});
    tbl.push_back('{1'b1, 32'h04,  32'h1122_3344, 2'd2, 1'b0, 0, 32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h06,  32'h0,         2'd2, 1'b0, 0, 32'h0,         1'b1});
    tbl.push_back('{1'b0, 32'h05,  32'h0,         2'd1, 1'b0, 0, 32'h0,         1'b1});
    tbl.push_back('{1'b0, 32'h00,  32'h0,         2'd3, 1'b0, 0, 32'h0,         1'b1});
    tbl.push_back('{1'b1, 32'(DEPTH*4), 32'hDEAD_BEEF, 2'd2, 1'b0, 0, 32'h0,    1'b1});
    tbl.push_back('{1'b1, 32'h07,  32'h0000_5555, 2'd1, 1'b0, 0, 32'h0,         1'b1});
    tbl.push_back('{1'b0, 32'h04,  32'h0,         2'd2, 1'b0, 0, 32'h1122_3344, 1'b0});
    tbl.push_back('{1'b0, 32'h10,  32'h0,         2'd0, 1'b0, 0, 32'h0000_0021, 1'b0});
    tbl.push_back('{1'b0, 32'h10,  32'h0,         2'd1, 1'b1, 0, 32'hFFFF_AB21, 1'b0});
    tbl.push_back('{1'b1, 32'h06,  32'h1234_BEEF, 2'd1, 1'b0, 0, 32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h04,  32'h0,         2'd2, 1'b0, 0, 32'hBEEF_3344, 1'b0});
    tbl.push_back('{1'b0, 32'h04,  32'h0,         2'd0, 1'b1, 0, 32'h0000_0044, 1'b0});
    foreach (tbl[i]) begin
      model(0, tbl[i].w, tbl[i].a, tbl[i].dat, tbl[i].l, tbl[i].s, mrd, me);
      txn(0, tbl[i].w, tbl[i].a, tbl[i].dat, tbl[i].l, tbl[i].s, tbl[i].hold, tbl[i].er, tbl[i].ee);
    end

    // Back-to-back on the LATENCY=0 instance: one response every 2 cycles.
    tbl.delete();
    tbl.push_back('{1'b1, 32'h20, 32'hCAFE_F00D, 2'd2, 1'b0, 0, 32'h0,         1'b0});
    tbl.push_back('{1'b0, 32'h22, 32'h0,         2'd1, 1'b1, 0, 32'hFFFF_CAFE, 1'b0});
    tbl.push_back('{1'b0, 32'h20, 32'h0,         2'd0, 1'b0, 0, 32'h0000_000D, 1'b0});
    tbl.push_back('{1'b0, 32'h20, 32'h0,         2'd2, 1'b0, 0, 32'hCAFE_F00D, 1'b0});
    tbl.push_back('{1'b0, 32'h21, 32'h0,         2'd2, 1'b0, 0, 32'h0,         1'b1});
    @(negedge clk);
    rr[1] = 1'b1;
    foreach (tbl[i]) begin
      model(1, tbl[i].w, tbl[i].a, tbl[i].dat, tbl[i].l, tbl[i].s, mrd, me);
      @(negedge clk);
      wr = tbl[i].w; addr = tbl[i].a; wd = tbl[i].dat; len = tbl[i].l; sg = tbl[i].s;
      rv[1] = 1'b1;
      @(posedge clk); #1;
      chk("b2b_valid", 32'(vld1), 32'd1);
      chk("b2b_rdata", rdat1, tbl[i].er);
      chk("b2b_error", 32'(err1), 32'(tbl[i].ee));
      chk("b2b_ready_low", 32'(rdy1), 32'd0);
      @(posedge clk); #1;
      chk("b2b_valid_drop", 32'(vld1), 32'd0);
      chk("b2b_ready_back", 32'(rdy1), 32'd1);
    end
    rv[1] = 1'b0;
    rr[1] = 1'b0;

    // Reset while a load sits in WAIT: transaction dropped, RAM intact.
    model(0, 1'b1, 32'h30, 32'h5A5A_A5A5, 2'd2, 1'b0, mrd, me);
    txn(0, 1'b1, 32'h30, 32'h5A5A_A5A5, 2'd2, 1'b0, 0, 32'h0, 1'b0);
    @(negedge clk);
    wr = 1'b0; addr = 32'h30; len = 2'd2; sg = 1'b0; rv[0] = 1'b1;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    chk("wait_ready_low", 32'(rdy0), 32'd0);
    chk("wait_valid_low", 32'(vld0), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready", 32'(rdy0), 32'd1);
    chk("midrst_valid", 32'(vld0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rr[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("no_rsp_after_rst", 32'(vld0), 32'd0);
    end
    rr[0] = 1'b0;
    txn(0, 1'b0, 32'h30, 32'h0, 2'd2, 1'b0, 0, 32'h5A5A_A5A5, 1'b0);

    // Random traffic: prefill words 0..15, then mixed accesses on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        dat = $urandom;
        model(d, 1'b1, 32'(i*4), dat, 2'd2, 1'b0, mrd, me);
        txn(d, 1'b1, 32'(i*4), dat, 2'd2, 1'b0, 0, mrd, me);
      end
    end
    for (int k = 0; k < 60; k++) begin
      int d;
      d   = int'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      s   = 1'($urandom_range(0, 1));
      l   = 2'($urandom_range(0, 3));
      dat = $urandom;
      a   = ($urandom_range(0, 7) == 0) ? 32'(DEPTH*4 + $urandom_range(0, 255))
                                        : 32'($urandom_range(0, 63));
      model(d, w, a, dat, l, s, mrd, me);
      txn(d, w, a, dat, l, s, int'($urandom_range(0, 2)), mrd, me);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
